// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM burst-read arbiter.
package sdram_arb_pkg;

    localparam int PORT_CMD                = 0;
    localparam int PORT_Z                  = 1;
    localparam int TAG_BEATS_BITS          = 8;
    localparam int MAX_OUTSTANDING_DEFAULT = 4;

    // One entry per burst in flight: which port issued it and how many beats it returns.
    typedef struct packed {
        logic                      id;
        logic [TAG_BEATS_BITS-1:0] beats;
    } tag_t;

endpackage

// File: rtl/burst_tag_fifo.sv
// Show-ahead synchronous FIFO holding the tags of bursts in flight.
module burst_tag_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_BITS = $clog2(DEPTH);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q;
    logic [PTR_BITS-1:0] rd_ptr_q;
    logic [PTR_BITS:0]   count_q;
    logic [PTR_BITS:0]   count_d;
    logic                do_push;
    logic                do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_BITS+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sdram_read_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM pipelined burst-read port between two masters;
// returned beats are steered by a tag FIFO of bursts in flight.
module sdram_read_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_BITS       = 29,
    parameter int BURST_BITS      = TAG_BEATS_BITS,
    parameter int DATA_BITS       = 64,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic [ADDR_BITS-1:0]                r0_address,
    input  logic [BURST_BITS-1:0]               r0_burstcount,
    input  logic                                r0_read,
    output logic                                r0_waitrequest,
    output logic [DATA_BITS-1:0]                r0_readdata,
    output logic                                r0_readdatavalid,
    input  logic [ADDR_BITS-1:0]                r1_address,
    input  logic [BURST_BITS-1:0]               r1_burstcount,
    input  logic                                r1_read,
    output logic                                r1_waitrequest,
    output logic [DATA_BITS-1:0]                r1_readdata,
    output logic                                r1_readdatavalid,
    output logic [ADDR_BITS-1:0]                m_address,
    output logic [BURST_BITS-1:0]               m_burstcount,
    output logic                                m_read,
    input  logic                                m_waitrequest,
    input  logic [DATA_BITS-1:0]                m_readdata,
    input  logic                                m_readdatavalid,
    output logic [$clog2(MAX_OUTSTANDING):0]    outstanding,
    output logic                                orphan_error
);

    logic                  rr_last_q;
    logic                  lock_q;
    logic                  lock_id_q;
    logic                  head_started_q;
    logic [BURST_BITS-1:0] beat_left_q;
    logic                  orphan_q;

    logic winner;
    logic win_read;
    logic accept;
    logic fifo_full;
    logic fifo_empty;
    logic beat_valid;
    logic last_beat;
    logic pop;
    tag_t push_tag;
    tag_t head_tag;

    // A stalled command keeps the bus until accepted; otherwise alternate on contention.
    always_comb begin
        if (lock_q) begin
            winner = lock_id_q;
        end else if (r0_read && r1_read) begin
            winner = !rr_last_q;
        end else begin
            winner = r1_read;
        end
    end

    assign win_read       = winner ? r1_read : r0_read;
    assign m_read         = reset_n && win_read && !fifo_full;
    assign m_address      = winner ? r1_address : r0_address;
    assign m_burstcount   = winner ? r1_burstcount : r0_burstcount;
    assign accept         = m_read && !m_waitrequest;
    assign r0_waitrequest = !(accept && winner == 1'(PORT_CMD));
    assign r1_waitrequest = !(accept && winner == 1'(PORT_Z));

    assign push_tag = '{id: winner, beats: m_burstcount};

    burst_tag_fifo #(
        .WIDTH ($bits(tag_t)),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (accept),
        .push_data (push_tag),
        .pop       (pop),
        .head      (head_tag),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (outstanding)
    );

    assign beat_valid       = m_readdatavalid && !fifo_empty;
    assign last_beat        = head_started_q ? (beat_left_q == BURST_BITS'(1))
                                             : (head_tag.beats == BURST_BITS'(1));
    assign pop              = beat_valid && last_beat;
    assign r0_readdatavalid = beat_valid && head_tag.id == 1'(PORT_CMD);
    assign r1_readdatavalid = beat_valid && head_tag.id == 1'(PORT_Z);
    assign r0_readdata      = m_readdata;
    assign r1_readdata      = m_readdata;
    assign orphan_error     = orphan_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_last_q      <= 1'b1;
            lock_q         <= 1'b0;
            lock_id_q      <= 1'b0;
            head_started_q <= 1'b0;
            beat_left_q    <= '0;
            orphan_q       <= 1'b0;
        end else begin
            if (accept) begin
                rr_last_q <= winner;
                lock_q    <= 1'b0;
            end else if (m_read && m_waitrequest) begin
                lock_q    <= 1'b1;
                lock_id_q <= winner;
            end

            // beat_left counts beats still due after the current one.
            if (beat_valid) begin
                if (last_beat) begin
                    head_started_q <= 1'b0;
                    beat_left_q    <= '0;
                end else if (head_started_q) begin
                    beat_left_q <= beat_left_q - 1'b1;
                end else begin
                    head_started_q <= 1'b1;
                    beat_left_q    <= head_tag.beats - 1'b1;
                end
            end

            if (m_readdatavalid && fifo_empty) begin
                orphan_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Bench for sdram_read_arbiter: grant vector table, directed return-path sequences,
// and a randomized run against a queue-based reference model.
module tb_sdram_read_arbiter;

    localparam int AB = 29;
    localparam int BB = 8;
    localparam int DB = 64;
    localparam int MO = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [AB-1:0] r0_address = '0, r1_address = '0, m_address;
    logic [BB-1:0] r0_burstcount = 8'd1, r1_burstcount = 8'd1, m_burstcount;
    logic          r0_read = 1'b0, r1_read = 1'b0, m_read;
    logic          r0_waitrequest, r1_waitrequest, m_waitrequest = 1'b0;
    logic [DB-1:0] r0_readdata, r1_readdata, m_readdata = '0;
    logic          r0_readdatavalid, r1_readdatavalid, m_readdatavalid = 1'b0;
    logic [2:0]    outstanding;
    logic          orphan_error;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    sdram_read_arbiter #(
        .ADDR_BITS(AB), .BURST_BITS(BB), .DATA_BITS(DB), .MAX_OUTSTANDING(MO)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .r0_address(r0_address), .r0_burstcount(r0_burstcount), .r0_read(r0_read),
        .r0_waitrequest(r0_waitrequest), .r0_readdata(r0_readdata), .r0_readdatavalid(r0_readdatavalid),
        .r1_address(r1_address), .r1_burstcount(r1_burstcount), .r1_read(r1_read),
        .r1_waitrequest(r1_waitrequest), .r1_readdata(r1_readdata), .r1_readdatavalid(r1_readdatavalid),
        .m_address(m_address), .m_burstcount(m_burstcount), .m_read(m_read),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .outstanding(outstanding), .orphan_error(orphan_error)
    );

    // Requesters never issue a zero-length burst.
    always @(posedge clock) begin
        if (r0_read) assert (r0_burstcount != 0) else $error("port 0 issued burstcount 0");
        if (r1_read) assert (r1_burstcount != 0) else $error("port 1 issued burstcount 0");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic clear_inputs;
        r0_read = 1'b0; r1_read = 1'b0;
        m_waitrequest = 1'b0; m_readdatavalid = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Return n beats; bit i of seq is the port that must see beat i.
    task automatic drain(input logic [15:0] seq, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            m_readdatavalid = 1'b1;
            m_readdata = {32'hBEEF_0000, 32'(i)};
            settle();
            chk({tag, " r0 valid"}, r0_readdatavalid, !seq[i]);
            chk({tag, " r1 valid"}, r1_readdatavalid, seq[i]);
            if (seq[i]) chk({tag, " r1 data"}, r1_readdata, m_readdata);
            else        chk({tag, " r0 data"}, r0_readdata, m_readdata);
            $display("beat %s %0d port=%0d data=%0h", tag, i, seq[i], m_readdata);
            tick();
        end
        m_readdatavalid = 1'b0;
        settle();
        chk({tag, " drained"}, outstanding, 0);
    endtask

    typedef struct {
        logic          rd0, rd1, stall;
        logic          exp_mread;
        logic [AB-1:0] exp_addr;
        logic          exp_w0, exp_w1;
        int            exp_out;
    } vec_t;

    typedef struct {
        int id;
        int rem;
    } burst_t;

    initial begin
        vec_t   vecs[9];
        burst_t q[$];
        burst_t h;
        int     last, locked, cand, pend;
        bit     req[2];
        logic [AB-1:0] addr[2];
        logic [BB-1:0] bc[2];
        bit     exp_mread, exp_acc, exp_v0, exp_v1;

        // Grant table: r0 at 0x100 len 2, r1 at 0x200 len 3, no beats returned.
        vecs[0] = '{1, 1, 0, 1, 29'h100, 0, 1, 0};
        vecs[1] = '{1, 1, 1, 1, 29'h200, 1, 1, 1};
        vecs[2] = '{1, 1, 1, 1, 29'h200, 1, 1, 1};
        vecs[3] = '{1, 1, 0, 1, 29'h200, 1, 0, 1};
        vecs[4] = '{1, 0, 1, 1, 29'h100, 1, 1, 2};
        vecs[5] = '{1, 1, 0, 1, 29'h100, 0, 1, 2};
        vecs[6] = '{0, 1, 0, 1, 29'h200, 1, 0, 3};
        vecs[7] = '{1, 1, 0, 0, 29'h100, 1, 1, 4};
        vecs[8] = '{1, 1, 0, 0, 29'h100, 1, 1, 4};

        // Outputs held safe while reset is asserted, even with requests and beats present.
        r0_read = 1'b1; r1_read = 1'b1; m_readdatavalid = 1'b1;
        tick();
        chk("reset m_read", m_read, 0);
        chk("reset r0_wait", r0_waitrequest, 1);
        chk("reset r1_wait", r1_waitrequest, 1);
        chk("reset r0_valid", r0_readdatavalid, 0);
        chk("reset r1_valid", r1_readdatavalid, 0);
        chk("reset outstanding", outstanding, 0);
        chk("reset orphan", orphan_error, 0);
        do_reset();

        r0_address = 29'h100; r0_burstcount = 8'd2;
        r1_address = 29'h200; r1_burstcount = 8'd3;
        for (int i = 0; i < 9; i++) begin
            r0_read = vecs[i].rd0; r1_read = vecs[i].rd1; m_waitrequest = vecs[i].stall;
            settle();
            chk("vec m_read", m_read, vecs[i].exp_mread);
            chk("vec m_address", m_address, vecs[i].exp_addr);
            chk("vec r0_wait", r0_waitrequest, vecs[i].exp_w0);
            chk("vec r1_wait", r1_waitrequest, vecs[i].exp_w1);
            chk("vec outstanding", outstanding, 64'(vecs[i].exp_out));
            $display("vec %0d rd=%b%b stall=%b m_read=%b addr=%0h", i, vecs[i].rd0, vecs[i].rd1,
                     vecs[i].stall, m_read, m_address);
            tick();
        end

        // Full FIFO: the pop of the first burst does not free a slot until the next cycle.
        r0_read = 1'b1; r1_read = 1'b0; m_waitrequest = 1'b0;
        m_readdatavalid = 1'b1; m_readdata = 64'hA0;
        settle();
        chk("full beat0 r0 valid", r0_readdatavalid, 1);
        chk("full beat0 m_read", m_read, 0);
        tick();
        m_readdata = 64'hA1;
        settle();
        chk("full beat1 r0 valid", r0_readdatavalid, 1);
        chk("full pop-cycle m_read", m_read, 0);
        tick();
        m_readdatavalid = 1'b0;
        settle();
        chk("after pop outstanding", outstanding, 3);
        chk("after pop m_read", m_read, 1);
        chk("after pop r0_wait", r0_waitrequest, 0);
        tick();
        r0_read = 1'b0;
        drain(16'h00E7, 10, "full");

        // Single port 0 burst of 4 beats returned two cycles after accept.
        r0_address = 29'h100; r0_burstcount = 8'd4; r0_read = 1'b1;
        settle();
        chk("single m_read", m_read, 1);
        chk("single m_address", m_address, 29'h100);
        chk("single m_burstcount", m_burstcount, 4);
        tick();
        r0_read = 1'b0;
        settle();
        chk("single outstanding", outstanding, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            m_readdatavalid = 1'b1; m_readdata = 64'hD0 + 64'(i);
            settle();
            chk("single r0 valid", r0_readdatavalid, 1);
            chk("single r0 data", r0_readdata, 64'hD0 + 64'(i));
            chk("single r1 valid", r1_readdatavalid, 0);
            tick();
        end
        m_readdatavalid = 1'b0;
        settle();
        chk("single drained", outstanding, 0);

        // Port 0 length 1 followed by port 1 length 3, beats back to back.
        r0_burstcount = 8'd1; r0_read = 1'b1;
        tick();
        r0_read = 1'b0; r1_burstcount = 8'd3; r1_read = 1'b1;
        settle();
        chk("len13 r1 accept", r1_waitrequest, 0);
        tick();
        r1_read = 1'b0;
        drain(16'h000E, 4, "len13");

        // Port 1 stalled five cycles while port 0 also requests: command stays locked.
        r1_address = 29'h2A0; r1_burstcount = 8'd2; r1_read = 1'b1;
        r0_address = 29'h100; r0_burstcount = 8'd2; m_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            r0_read = (i >= 1);
            settle();
            chk("lock m_address", m_address, 29'h2A0);
            chk("lock r1_wait", r1_waitrequest, 1);
            chk("lock r0_wait", r0_waitrequest, 1);
            tick();
        end
        m_waitrequest = 1'b0;
        settle();
        chk("lock release r1_wait", r1_waitrequest, 0);
        chk("lock release r0_wait", r0_waitrequest, 1);
        tick();
        r1_read = 1'b0;
        settle();
        chk("lock next r0_wait", r0_waitrequest, 0);
        chk("lock next m_address", m_address, 29'h100);
        tick();
        r0_read = 1'b0;
        drain(16'h0003, 4, "lock");

        // Orphan beat: dropped, sticky flag until reset.
        m_readdatavalid = 1'b1;
        settle();
        chk("orphan r0 valid", r0_readdatavalid, 0);
        chk("orphan r1 valid", r1_readdatavalid, 0);
        tick();
        m_readdatavalid = 1'b0;
        tick();
        tick();
        chk("orphan sticky", orphan_error, 1);
        do_reset();
        settle();
        chk("orphan cleared", orphan_error, 0);

        // Randomized traffic against a queue-of-bursts reference model.
        last = 1; locked = -1;
        req[0] = 0; req[1] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req[p] && $urandom_range(0, 2) == 0) begin
                    req[p]  = 1;
                    addr[p] = AB'($urandom);
                    bc[p]   = BB'($urandom_range(1, 4));
                end
            end
            pend = 0;
            foreach (q[k]) pend += q[k].rem;
            r0_read = req[0]; r0_address = addr[0]; r0_burstcount = bc[0];
            r1_read = req[1]; r1_address = addr[1]; r1_burstcount = bc[1];
            m_waitrequest = ($urandom_range(0, 3) == 0);
            m_readdatavalid = (pend > 0) && $urandom_range(0, 1) == 1;
            m_readdata = {$urandom, $urandom};
            settle();

            if (locked >= 0) cand = locked;
            else if (req[0] && req[1]) cand = 1 - last;
            else cand = req[1] ? 1 : 0;
            exp_mread = req[cand] && (q.size() < MO);
            exp_acc   = exp_mread && !m_waitrequest;
            exp_v0    = m_readdatavalid && q.size() > 0 && q[0].id == 0;
            exp_v1    = m_readdatavalid && q.size() > 0 && q[0].id == 1;

            chk("rand m_read", m_read, exp_mread);
            if (exp_mread) begin
                chk("rand m_address", m_address, addr[cand]);
                chk("rand m_burstcount", m_burstcount, bc[cand]);
            end
            chk("rand r0_wait", r0_waitrequest, !(exp_acc && cand == 0));
            chk("rand r1_wait", r1_waitrequest, !(exp_acc && cand == 1));
            chk("rand r0 valid", r0_readdatavalid, exp_v0);
            chk("rand r1 valid", r1_readdatavalid, exp_v1);
            chk("rand outstanding", outstanding, 64'(q.size()));
            if (exp_acc) $display("rand %0d accept port=%0d addr=%0h len=%0d", cyc, cand, addr[cand], bc[cand]);

            if (m_readdatavalid && q.size() > 0) begin
                h = q[0];
                h.rem--;
                if (h.rem == 0) void'(q.pop_front());
                else q[0] = h;
            end
            if (exp_acc) begin
                q.push_back('{cand, int'(bc[cand])});
                last = cand;
                locked = -1;
                req[cand] = 0;
            end else if (exp_mread && m_waitrequest) begin
                locked = cand;
            end
            tick();
        end
        chk("rand orphan", orphan_error, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_read_arbiter.md
Name: sdram_read_arbiter

Overview:
- Shares one HPS F2H SDRAM Avalon-MM pipelined burst-read port between two read masters.
- Port 0 is command-buffer fetch; port 1 is Z-pixel read. Both sit inside the rasterizer's sdram1 path.
- Round-robin grant, locked while the bus stalls.
- A tag FIFO tracks outstanding bursts so that every returned beat is steered to the master that issued it.

Parameters:
- ADDR_BITS, 29, width of the SDRAM word address.
- BURST_BITS, 8, width of burstcount.
- DATA_BITS, 64, width of readdata.
- MAX_OUTSTANDING, 4, depth of the tag FIFO (maximum bursts in flight); power of two.

Ports:
- clock  in  1  system clock (clock_50 domain)
- reset_n  in  1  asynchronous active-low reset
- r0_address  in  ADDR_BITS  port 0 burst start address
- r0_burstcount  in  BURST_BITS  port 0 beats, 1..2^BURST_BITS-1
- r0_read  in  1  port 0 request
- r0_waitrequest  out  1  port 0 stall
- r0_readdata  out  DATA_BITS  port 0 data
- r0_readdatavalid  out  1  port 0 beat valid
- r1_address / r1_burstcount / r1_read / r1_waitrequest / r1_readdata / r1_readdatavalid  same as r0, for port 1
- m_address  out  ADDR_BITS  to SDRAM port
- m_burstcount  out  BURST_BITS  to SDRAM port
- m_read  out  1  to SDRAM port
- m_waitrequest  in  1  from SDRAM port
- m_readdata  in  DATA_BITS  from SDRAM port
- m_readdatavalid  in  1  from SDRAM port
- outstanding  out  clog2(MAX_OUTSTANDING)+1  bursts in flight (debug)
- orphan_error  out  1  sticky: a beat arrived with no burst in flight

Behaviour:
- Reset (asynchronous, reset_n low) clears:
  - rr_last = 1, so port 0 wins first;
  - lock = 0; the tag FIFO (empty, count 0); beat_left = 0; orphan_error = 0.
- Outputs while in reset: m_read = 0, r*_readdatavalid = 0, r*_waitrequest = 1.
- Grant:
  - If lock = 1, winner = lock_id.
  - Otherwise, if both ports request, winner = !rr_last; if only one requests, winner = that port.
  - m_read = winner's r*_read && !full, where full = (count == MAX_OUTSTANDING) and uses the registered count.
  - m_address / m_burstcount are muxed combinationally from the winner.
- Accept: accept = m_read && !m_waitrequest.
  - On accept: push {id = winner, beats = winner burstcount} to the tag FIFO; set rr_last = winner; clear lock.
- Lock: if m_read && m_waitrequest, set lock = 1 and lock_id = winner.
  - The master-side command stays stable until accepted, as Avalon requires.
  - The other port cannot preempt it.
- Requester waitrequest:
  - r*_waitrequest = !(winner == port && accept).
  - A non-winning port, or any port while full, sees waitrequest = 1.
- Return path:
  - r0_readdata and r1_readdata are driven directly from m_readdata (fan-out, no register).
  - r*_readdatavalid = m_readdatavalid && FIFO non-empty && head.id == port.
  - Zero-latency combinational steering.
- Beat counting:
  - On the first beat of the head burst, load beat_left = head.beats - 1.
  - Each later beat decrements beat_left.
  - When the last beat arrives (beats = 1 or beat_left = 1), pop the head.
  - Use a head_started flag to tell the first beat apart from later ones.
- Simultaneous push and pop: allowed in the same cycle; count stays unchanged.
  - A pop does not relieve full in the same cycle. The waiting port is accepted one cycle later at the earliest.
- Orphan beat: m_readdatavalid with an empty FIFO is dropped (no port sees valid) and orphan_error is set. orphan_error clears only on reset.
- Zero burstcount: requesters never issue burstcount 0; the bench asserts this. The arbiter forwards it unchanged.
- Reset mid-burst: in-flight bursts are forgotten. Later beats from SDRAM are treated as orphans; orphan_error is expected and ignored by the system after reset.
- Latency: request to m_read is 0 cycles (combinational). The arbiter adds no pipeline stage on either path.

Decomposition:
- Shared package sdram_arb_pkg:
  - PORT_CMD = 0, PORT_Z = 1;
  - the tag record type {id: 1 bit, beats: BURST_BITS};
  - a MAX_OUTSTANDING default constant.
- Sub-module burst_tag_fifo:
  - synchronous FIFO with registered count, full/empty flags and head output (show-ahead);
  - the same async reset.
- The top level holds grant, lock and beat counting.

Test Plan:
- Single port 0 request: address 0x100, burstcount 4, m_waitrequest = 0, 4 beats D0..D3 two cycles later -> r0_readdatavalid high 4 times carrying D0..D3; r1_readdatavalid never high; outstanding goes 1 then 0.
- Both ports request in the same cycle, repeated 4 times, no stall -> accepts alternate 0,1,0,1; the tag FIFO order matches; returned beats are steered alternately.
- Port 1 request with m_waitrequest held high for 5 cycles while port 0 also requests -> m_address stays equal to r1_address for all 5 cycles; port 1 is accepted on cycle 6; port 0 is accepted next.
- 4 bursts outstanding (MAX_OUTSTANDING = 4) with a 5th request pending -> m_read = 0 until the first burst's last beat pops; accept occurs the cycle after the pop.
- Burst port 0 len 1, then port 1 len 3, data back-to-back -> beat 1 goes to r0, beats 2-4 go to r1; the FIFO empties.
- m_readdatavalid pulse with an empty FIFO -> no port valid; orphan_error = 1 and stays high until reset_n pulses low.
